// File: rtl/dram_word_port.sv
// dram_word_port: 32-bit CPU word port onto a 128-bit DRAM line channel.
// One line buffer serves read hits; writes merge into the line (RMW when the
// line is not buffered) and are always written through as a full line.
module dram_word_port #(
    parameter int ADDR_W  = 25,
    parameter bit USE_BUF = 1'b1
) (
    input  logic              clk,
    input  logic              sys_rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              dram_req_en,
    input  logic              dram_req_rdy,
    output logic [26:0]       dram_req_addr,
    output logic [127:0]      dram_req_data,
    output logic              dram_req_cmd,
    input  logic              dram_rsp_en,
    input  logic [127:0]      dram_rsp_data,
    output logic              err_rsp
);

    localparam int LINE_W = ADDR_W - 2;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    logic [2:0]        r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [127:0]      r_buf;
    logic [LINE_W-1:0] r_buf_line;
    logic              r_buf_valid;
    logic              r_err;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_dreq_en;
    logic [26:0]       r_dreq_addr;
    logic [127:0]      r_dreq_data;
    logic              r_dreq_cmd;

    logic [LINE_W-1:0] w_req_line;
    logic [26:0]       w_req_laddr;
    logic              w_hit;
    logic [127:0]      w_hit_merge;
    logic [127:0]      w_fill_merge;

    // Overlay the enabled bytes of wd onto word widx of a line.
    function automatic logic [127:0] merge_line(input logic [127:0] line,
                                                input logic [1:0]   widx,
                                                input logic [3:0]   be,
                                                input logic [31:0]  wd);
        logic [127:0] m;
        m = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[int'(widx)*32 + b*8 +: 8] = wd[b*8 +: 8];
        end
        return m;
    endfunction

    function automatic logic [31:0] get_word(input logic [127:0] line,
                                             input logic [1:0]   widx);
        return line[int'(widx)*32 +: 32];
    endfunction

    assign w_req_line   = req_addr[ADDR_W-1:2];
    assign w_req_laddr  = 27'({w_req_line, 3'b000});
    assign w_hit        = USE_BUF && r_buf_valid && (r_buf_line == w_req_line);
    // Write hit merges the incoming word into the buffered line.
    assign w_hit_merge  = merge_line(r_buf, req_addr[1:0], req_be, req_wdata);
    // Write miss merges the latched word into the freshly fetched line.
    assign w_fill_merge = merge_line(dram_rsp_data, r_addr[1:0], r_be, r_wdata);

    assign req_ready     = (r_state == IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign dram_req_en   = r_dreq_en;
    assign dram_req_addr = r_dreq_addr;
    assign dram_req_data = r_dreq_data;
    assign dram_req_cmd  = r_dreq_cmd;
    assign err_rsp       = r_err;

    // Sticky error: a line response arriving when none is outstanding.
    always_ff @(posedge clk or negedge sys_rst_i) begin
        if (!sys_rst_i)                              r_err <= 1'b0;
        else if (dram_rsp_en && r_state != RD_WAIT)  r_err <= 1'b1;
    end

    // Main control FSM; one DRAM request in flight, responses are in order.
    always_ff @(posedge clk or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_buf        <= '0;
            r_buf_line   <= '0;
            r_buf_valid  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_dreq_en    <= 1'b0;
            r_dreq_addr  <= '0;
            r_dreq_data  <= '0;
            r_dreq_cmd   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_be    <= req_be;
                        r_wdata <= req_wdata;
                        if (w_hit && !req_we) begin
                            r_state <= RESP;
                        end else if (w_hit) begin
                            r_buf       <= w_hit_merge;
                            r_dreq_data <= w_hit_merge;
                            r_dreq_addr <= w_req_laddr;
                            r_dreq_cmd  <= 1'b0;
                            r_dreq_en   <= 1'b1;
                            r_state     <= WR_REQ;
                        end else begin
                            r_dreq_addr <= w_req_laddr;
                            r_dreq_cmd  <= 1'b1;
                            r_dreq_en   <= 1'b1;
                            r_state     <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (dram_req_rdy) begin
                        r_dreq_en <= 1'b0;
                        r_state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (dram_rsp_en) begin
                        r_buf_line  <= r_addr[ADDR_W-1:2];
                        r_buf_valid <= USE_BUF;
                        if (!r_we) begin
                            r_buf   <= dram_rsp_data;
                            r_state <= RESP;
                        end else begin
                            // Request address is still the fetched line.
                            r_buf       <= w_fill_merge;
                            r_dreq_data <= w_fill_merge;
                            r_dreq_cmd  <= 1'b0;
                            r_dreq_en   <= 1'b1;
                            r_state     <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (dram_req_rdy) begin
                        r_dreq_en <= 1'b0;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_we ? 32'h0 : get_word(r_buf, r_addr[1:0]);
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_word_port.sv
// Directed bench for dram_word_port; responses checked by a scoreboard monitor.
module tb_dram_word_port;

    logic         clk = 1'b0;
    logic         sys_rst_i = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [24:0]  req_addr = '0;
    logic [3:0]   req_be = '0;
    logic [31:0]  req_wdata = '0;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         dram_req_en;
    logic         dram_req_rdy = 1'b0;
    logic [26:0]  dram_req_addr;
    logic [127:0] dram_req_data;
    logic         dram_req_cmd;
    logic         dram_rsp_en = 1'b0;
    logic [127:0] dram_rsp_data = '0;
    logic         err_rsp;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    logic [31:0] exp_q[$];

    dram_word_port #(.ADDR_W(25), .USE_BUF(1'b1)) dut (
        .clk(clk), .sys_rst_i(sys_rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .dram_req_en(dram_req_en), .dram_req_rdy(dram_req_rdy),
        .dram_req_addr(dram_req_addr), .dram_req_data(dram_req_data),
        .dram_req_cmd(dram_req_cmd), .dram_rsp_en(dram_rsp_en),
        .dram_rsp_data(dram_rsp_data), .err_rsp(err_rsp)
    );

    always #5 clk = ~clk;

    // Count completed DRAM write transfers.
    always @(posedge clk) begin
        if (dram_req_en && dram_req_rdy && !dram_req_cmd) wr_cnt++;
    end

    // Scoreboard monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (sys_rst_i && resp_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL resp_unexpected: got rdata=%h, wanted no response", resp_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (resp_rdata !== e) begin
                    n_errors++;
                    $display("FAIL resp_rdata: got %h, wanted %h", resp_rdata, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // Issue one CPU request; returns one tick after the accepting edge (cycle 1).
    task automatic cpu_req(input logic we, input logic [24:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input bit push, input logic [31:0] exp);
        bit done = 0;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        req_valid = 1'b0;
        if (!done) chk("req_accept_timeout", 0, 1);
    endtask

    // Wait for a DRAM request, check its fields, optionally stall, then accept.
    task automatic dram_serve(input string name, input logic cmd, input logic [26:0] addr,
                              input logic [127:0] data, input bit chk_data,
                              input int exp_wait, input int stall);
        int n = 0;
        bit seen = 0;
        logic [155:0] snap;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (dram_req_en) seen = 1;
        end
        if (!seen) begin
            chk({name, "_timeout"}, 0, 1);
            return;
        end
        if (exp_wait > 0) chk({name, "_latency"}, n, exp_wait);
        chk({name, "_cmd"}, dram_req_cmd, cmd);
        chk({name, "_addr"}, dram_req_addr, addr);
        if (chk_data) chk({name, "_data"}, dram_req_data, data);
        snap = {dram_req_cmd, dram_req_addr, dram_req_data};
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, "_stall_en"}, dram_req_en, 1);
            chk({name, "_stall_fields"}, 128'({dram_req_cmd, dram_req_addr, dram_req_data} != snap), 0);
        end
        #1 dram_req_rdy = 1'b1;
        @(posedge clk); #1;
        dram_req_rdy = 1'b0;
    endtask

    // Return one read line; returns one tick after the response edge.
    task automatic dram_return(input logic [127:0] line);
        @(negedge clk); #1;
        dram_rsp_en = 1'b1; dram_rsp_data = line;
        @(posedge clk); #1;
        dram_rsp_en = 1'b0; dram_rsp_data = '0;
    endtask

    initial begin
        int w0;
        // Reset state.
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_dram_req_en", dram_req_en, 0);
        chk("rst_err_rsp", err_rsp, 0);
        sys_rst_i = 1'b1;

        // Read miss at 0x5: line 1 -> DRAM address 0x8, word 1 returned.
        cpu_req(0, 25'h0000005, 4'h0, 32'h0, 1, 32'h00000022);
        dram_serve("rdmiss", 1, 27'h0000008, '0, 0, 1, 0);
        dram_return({32'h44, 32'h33, 32'h22, 32'h11});
        @(negedge clk); chk("rdmiss_lat_c1", resp_valid, 0);
        @(negedge clk); chk("rdmiss_lat_c2", resp_valid, 1);
        chk("rdmiss_err", err_rsp, 0);

        // Read hit at 0x7: served locally at cycle 2.
        w0 = wr_cnt;
        cpu_req(0, 25'h0000007, 4'h0, 32'h0, 1, 32'h00000044);
        @(negedge clk); chk("rdhit_c1_valid", resp_valid, 0); chk("rdhit_c1_en", dram_req_en, 0);
        @(negedge clk); chk("rdhit_c2_valid", resp_valid, 1); chk("rdhit_c2_en", dram_req_en, 0);

        // Write hit at 0x6 (word 2 = 0x33), be 0101 -> 0x00BB00DD.
        cpu_req(1, 25'h0000006, 4'b0101, 32'hAABBCCDD, 1, 32'h0);
        dram_serve("wrhit", 0, 27'h0000008,
                   {32'h44, 32'h00BB00DD, 32'h22, 32'h11}, 1, 1, 0);
        chk("wrhit_count", wr_cnt - w0, 1);
        cpu_req(0, 25'h0000006, 4'h0, 32'h0, 1, 32'h00BB00DD);

        // RMW miss at 0x100 with 5-cycle write backpressure.
        cpu_req(1, 25'h0000100, 4'b0011, 32'hAABBCCDD, 1, 32'h0);
        dram_serve("rmw_rd", 1, 27'h0000200, '0, 0, 1, 0);
        dram_return({32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'h12345678});
        w0 = wr_cnt;
        dram_serve("rmw_wr", 0, 27'h0000200,
                   {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'h1234CCDD}, 1, 0, 5);
        repeat (4) @(negedge clk);
        chk("rmw_wr_count", wr_cnt - w0, 1);

        // be = 0000 write hit still writes the unchanged line.
        cpu_req(1, 25'h0000101, 4'b0000, 32'hFFFFFFFF, 1, 32'h0);
        dram_serve("be0", 0, 27'h0000200,
                   {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'h1234CCDD}, 1, 1, 0);

        // Reset during RD_WAIT, then a stale response.
        cpu_req(0, 25'h0000040, 4'h0, 32'h0, 0, 32'h0);
        dram_serve("rst_rd", 1, 27'h0000080, '0, 0, 1, 0);
        @(negedge clk); #1 sys_rst_i = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_dram_req_en", dram_req_en, 0);
        @(posedge clk); #1 sys_rst_i = 1'b1;
        dram_return({4{32'hDEAD0000}});
        @(negedge clk);
        chk("stale_err_rsp", err_rsp, 1);
        chk("stale_req_ready", req_ready, 1);
        repeat (3) @(negedge clk);
        // Buffer was invalidated: the former hit line must be fetched again.
        cpu_req(0, 25'h0000101, 4'h0, 32'h0, 1, 32'h5A5A0001);
        dram_serve("postrst", 1, 27'h0000200, '0, 0, 1, 0);
        dram_return({32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000});

        // Maximum address.
        cpu_req(0, 25'h1FFFFFF, 4'h0, 32'h0, 1, 32'h77777777);
        dram_serve("maxaddr", 1, 27'h3FFFFF8, '0, 0, 1, 0);
        dram_return({32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444});

        repeat (6) @(negedge clk);
        chk("err_sticky", err_rsp, 1);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "timeout");
    end

endmodule
